// File: rtl/elevator_pkg.sv
// Elevator controller shared types: FSM state encodings
// and travel direction constants.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/elevator_req_reg.sv
// Pending floor-request register with latch/clear logic.
// Ports: clk, rst, floor_req, floor_pos, block_here,
//   clr_en/clr_idx (stop clear), pending, above, below, here.
module elevator_req_reg #(
  parameter int FLOORS = 8,
  parameter int POS_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] floor_req,
  input  logic [POS_W-1:0]  floor_pos,
  input  logic              block_here,
  input  logic              clr_en,
  input  logic [POS_W-1:0]  clr_idx,
  output logic [FLOORS-1:0] pending,
  output logic              above,
  output logic              below,
  output logic              here
);

  logic [FLOORS-1:0] pend_q, pend_d;
  logic [FLOORS-1:0] here_mask, clr_mask;

  always_comb begin
    here_mask = '0;
    clr_mask  = '0;
    here_mask[floor_pos] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    // A press at the current floor while parked or
    // door-open reopens the door instead of latching.
    pend_d = pend_q
           | (floor_req & ~(block_here ? here_mask : '0));
    pend_d = pend_d & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(floor_pos)) above = above | pend_q[i];
      if (i < int'(floor_pos)) below = below | pend_q[i];
    end
  end

  assign here    = pend_q[floor_pos];
  assign pending = pend_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator car controller: FSM, direction, travel and
// door timers, estop freeze. Ports: clk, rst, floor_req, estop,
// floor_pos, door_open, moving_up, moving_down, pending, idle.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int FLOORS     = 8,
  parameter int POS_W      = 3,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] floor_req,
  input  logic              estop,
  output logic [POS_W-1:0]  floor_pos,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_down,
  output logic [FLOORS-1:0] pending,
  output logic              idle
);

  localparam int TW =
    (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW =
    (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d, npos;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;

  logic             clr_en;
  logic [POS_W-1:0] clr_idx;
  logic             above, below, here;
  logic             ahead, behind;
  logic             block_here;

  // While frozen, a current-floor press latches so it is
  // served after release rather than lost.
  assign block_here = !estop
    && (state_q == ST_IDLE || state_q == ST_DOOR);

  elevator_req_reg #(
    .FLOORS (FLOORS),
    .POS_W  (POS_W)
  ) u_req (
    .clk        (clk),
    .rst        (rst),
    .floor_req  (floor_req),
    .floor_pos  (pos_q),
    .block_here (block_here),
    .clr_en     (clr_en),
    .clr_idx    (clr_idx),
    .pending    (pending),
    .above      (above),
    .below      (below),
    .here       (here)
  );

  assign ahead  = (dir_q == DIR_UP) ? above : below;
  assign behind = (dir_q == DIR_UP) ? below : above;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pos_d   = pos_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    clr_en  = 1'b0;
    clr_idx = pos_q;
    npos    = pos_q;
    if (!estop) begin
      unique case (state_q)
        ST_IDLE: begin
          tcnt_d = '0;
          dcnt_d = '0;
          if (floor_req[pos_q] || here) begin
            state_d = ST_DOOR;
            clr_en  = 1'b1;
          end else if (above
                   && (dir_q == DIR_UP || !below)) begin
            state_d = ST_MOVE_UP;
            dir_d   = DIR_UP;
          end else if (below) begin
            state_d = ST_MOVE_DOWN;
            dir_d   = DIR_DOWN;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (tcnt_q == TW'(TRAVEL_CYC - 1)) begin
            tcnt_d = '0;
            if (state_q == ST_MOVE_UP) begin
              if (pos_q != POS_W'(FLOORS - 1))
                npos = pos_q + POS_W'(1);
            end else begin
              if (pos_q != '0)
                npos = pos_q - POS_W'(1);
            end
            pos_d = npos;
            if (pending[npos]) begin
              state_d = ST_DOOR;
              dcnt_d  = '0;
              clr_en  = 1'b1;
              clr_idx = npos;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_DOOR: begin
          if (floor_req[pos_q]) begin
            dcnt_d = '0;
          end else if (dcnt_q == DW'(DOOR_CYC - 1)) begin
            dcnt_d = '0;
            tcnt_d = '0;
            if (ahead) begin
              state_d = (dir_q == DIR_UP)
                      ? ST_MOVE_UP : ST_MOVE_DOWN;
            end else if (behind) begin
              state_d = (dir_q == DIR_UP)
                      ? ST_MOVE_DOWN : ST_MOVE_UP;
              dir_d   = (dir_q == DIR_UP)
                      ? DIR_DOWN : DIR_UP;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      pos_q   <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pos_q   <= pos_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign floor_pos   = pos_q;
  assign door_open   = (state_q == ST_DOOR);
  assign moving_up   = (state_q == ST_MOVE_UP) && !estop;
  assign moving_down = (state_q == ST_MOVE_DOWN) && !estop;
  assign idle        = (state_q == ST_IDLE)
                    && (pending == '0);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed vector bench for elevator_scan_ctrl
// (8 floors, 4-cycle travel, 3-cycle door).
module tb_elevator_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] floor_req = '0;
  logic       estop = 1'b0;
  logic [2:0] floor_pos;
  logic       door_open, moving_up, moving_down, idle;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  elevator_scan_ctrl #(
    .FLOORS     (8),
    .POS_W      (3),
    .TRAVEL_CYC (4),
    .DOOR_CYC   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .floor_req   (floor_req),
    .estop       (estop),
    .floor_pos   (floor_pos),
    .door_open   (door_open),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .pending     (pending),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       es;
    logic [2:0] pos;
    logic       door;
    logic       up;
    logic       dn;
    logic [7:0] pend;
    logic       idl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic [7:0] req,
                     input logic es, input logic [2:0] pos,
                     input logic door, input logic up,
                     input logic dn, input logic [7:0] pend,
                     input logic idl);
    vec_t v;
    v.req = req; v.es = es; v.pos = pos; v.door = door;
    v.up = up; v.dn = dn; v.pend = pend; v.idl = idl;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic check(input string nm,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {3'b0, floor_pos, door_open, moving_up,
            moving_down, pending, idle};
  endfunction

  initial begin
    // press 0 at floor 0: door for 3 cycles
    add(1, 8'h01, 0, 0, 1, 0, 0, 8'h00, 0);
    add(2, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1);
    // press 3: latch, then 12 cycles of travel
    add(1, 8'h08, 0, 0, 0, 0, 0, 8'h08, 0);
    add(4, 8'h00, 0, 0, 0, 1, 0, 8'h08, 0);
    add(4, 8'h00, 0, 1, 0, 1, 0, 8'h08, 0);
    add(4, 8'h00, 0, 2, 0, 1, 0, 8'h08, 0);
    add(1, 8'h00, 0, 3, 1, 0, 0, 8'h00, 0);
    // at 3 call 6, then press 1 and 5 en route
    add(1, 8'h40, 0, 3, 1, 0, 0, 8'h40, 0);
    add(1, 8'h00, 0, 3, 1, 0, 0, 8'h40, 0);
    add(1, 8'h00, 0, 3, 0, 1, 0, 8'h40, 0);
    add(1, 8'h22, 0, 3, 0, 1, 0, 8'h62, 0);
    add(2, 8'h00, 0, 3, 0, 1, 0, 8'h62, 0);
    add(4, 8'h00, 0, 4, 0, 1, 0, 8'h62, 0);
    add(3, 8'h00, 0, 5, 1, 0, 0, 8'h42, 0);
    add(4, 8'h00, 0, 5, 0, 1, 0, 8'h42, 0);
    add(3, 8'h00, 0, 6, 1, 0, 0, 8'h02, 0);
    add(4, 8'h00, 0, 6, 0, 0, 1, 8'h02, 0);
    add(4, 8'h00, 0, 5, 0, 0, 1, 8'h02, 0);
    add(4, 8'h00, 0, 4, 0, 0, 1, 8'h02, 0);
    add(4, 8'h00, 0, 3, 0, 0, 1, 8'h02, 0);
    add(4, 8'h00, 0, 2, 0, 0, 1, 8'h02, 0);
    add(3, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1);
    // from 1 call 3, estop 5 cycles mid-travel
    add(1, 8'h08, 0, 1, 0, 0, 0, 8'h08, 0);
    add(2, 8'h00, 0, 1, 0, 1, 0, 8'h08, 0);
    add(1, 8'h10, 1, 1, 0, 0, 0, 8'h18, 0);
    add(4, 8'h00, 1, 1, 0, 0, 0, 8'h18, 0);
    add(2, 8'h00, 0, 1, 0, 1, 0, 8'h18, 0);
    add(4, 8'h00, 0, 2, 0, 1, 0, 8'h18, 0);
    add(3, 8'h00, 0, 3, 1, 0, 0, 8'h10, 0);
    add(4, 8'h00, 0, 3, 0, 1, 0, 8'h10, 0);
    add(3, 8'h00, 0, 4, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 4, 0, 0, 0, 8'h00, 1);
    // door reopen: second press reloads dwell
    add(1, 8'h10, 0, 4, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 4, 1, 0, 0, 8'h00, 0);
    add(1, 8'h10, 0, 4, 1, 0, 0, 8'h00, 0);
    add(2, 8'h00, 0, 4, 1, 0, 0, 8'h00, 0);
    add(1, 8'h00, 0, 4, 0, 0, 0, 8'h00, 1);
    // calls 5 and 7, start moving up
    add(1, 8'hA0, 0, 4, 0, 0, 0, 8'hA0, 0);
    add(2, 8'h00, 0, 4, 0, 1, 0, 8'hA0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", outs(), 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_idle", outs(), 16'h0001);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      floor_req = vq[i].req;
      estop     = vq[i].es;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            {3'b0, vq[i].pos, vq[i].door, vq[i].up,
             vq[i].dn, vq[i].pend, vq[i].idl});
      check($sformatf("excl%0d", i),
            {14'b0, moving_up & moving_down,
             door_open & (moving_up | moving_down)},
            16'h0000);
    end

    // asynchronous reset mid-travel with pending 0xA0
    @(negedge clk);
    floor_req = '0;
    estop     = 1'b0;
    rst       = 1'b1;
    #1;
    check("rst_async", outs(), 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_after", outs(), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
